// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The transmitter imports the same bit-period default so both ends stay matched.
package uart_pkg;

   localparam int UART_DATA_W         = 8;
   localparam int UART_BIT_CYCLES_DEF = 10;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
// All flops reset high so a line released from reset never looks like a start edge.
module rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic line,
   output logic fall
);

   logic meta;
   logic sync;
   logic sync_dly;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta     <= 1'b1;
         sync     <= 1'b1;
         sync_dly <= 1'b1;
      end else begin
         meta     <= din;
         sync     <= meta;
         sync_dly <= sync;
      end
   end

   assign line = sync;
   assign fall = sync_dly & ~sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, pushes good bytes into an RX FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BIT_CYCLES = UART_BIT_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   uart,
   input  logic                   full,
   output logic [UART_DATA_W-1:0] data,
   output logic                   write,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   parity_err
);

   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CW          = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CYCLES - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYCLES - 1);

   rx_state_t              state;
   rx_state_t              state_nxt;
   logic                   line;
   logic                   fall;
   logic [CW-1:0]          cnt;
   logic [2:0]             bitn;
   logic [UART_DATA_W-1:0] shifter;
   logic                   tick;
   logic                   stop_sample;
   logic                   par_bad;
   logic                   write_nxt;
   logic                   frame_nxt;
   logic                   overrun_nxt;
   logic                   parity_nxt;

   rx_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (uart),
      .line (line),
      .fall (fall)
   );

   assign tick = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Break (line held low) never retriggers: IDLE only leaves on a fresh falling edge.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (fall) state_nxt = START;
         START: if (tick) state_nxt = line ? IDLE : DATA;
         DATA: begin
            if (tick && bitn == 3'd7) begin
`ifdef UART_RX_PARITY_EN
               state_nxt = PAR;
`else
               state_nxt = STOP;
`endif
            end
         end
         PAR:   if (tick) state_nxt = STOP;
         STOP:  if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;
`endif

   // Stop-bit decision: framing beats parity, parity beats overrun.
   always_comb begin
      par_bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     = ^{shifter, par_bit};
`endif
      stop_sample = (state == STOP) && tick;
      frame_nxt   = stop_sample && !line;
      parity_nxt  = stop_sample && line && par_bad;
      overrun_nxt = stop_sample && line && !par_bad && full;
      write_nxt   = stop_sample && line && !par_bad && !full;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt       <= '0;
         bitn      <= '0;
         shifter   <= '0;
         data      <= '0;
         write     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         write     <= write_nxt;
         frame_err <= frame_nxt;
         overrun   <= overrun_nxt;
         if (write_nxt) begin
            data <= shifter;
         end
         case (state)
            IDLE: if (fall) cnt <= HALF_LOAD;
            START: begin
               if (tick) begin
                  cnt  <= BIT_LOAD;
                  bitn <= '0;
               end else begin
                  cnt  <= cnt - 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  cnt     <= BIT_LOAD;
                  shifter <= {line, shifter[UART_DATA_W-1:1]};
                  if (bitn != 3'd7) begin
                     bitn <= bitn + 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PAR: begin
               if (tick) begin
                  cnt     <= BIT_LOAD;
                  par_bit <= line;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`endif
            STOP: if (!tick) cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= parity_nxt;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
